sbqm_sensor_conditioner: RTL and testbench

Conditions the two raw photo-sensor lines of the bank queue (back sensor at the queue entry, front sensor at the teller end) into clean single-cycle `upSignal`/`downSignal` events for the queue `Unit`. Each channel is synchronised, debounced and rising-edge detected. An arbiter then drops events the queue cannot accept, as judged from the `Unit` full/empty flags, and serialises simultaneous enter/leave events. Sits directly upstream of `Unit`; its event outputs drive `Unit.upSignal`/`Unit.downSignal`, and `Unit.fullFlag`/`Unit.emptyFlag` feed back into it.

---
 rtl/sbqm_sensor_conditioner_if.sv | 24 ++
 rtl/sbqm_sensor_conditioner.sv | 107 ++++++++++
 tb/tb_sbqm_sensor_conditioner.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/sbqm_sensor_conditioner_if.sv
// Sensor-side and Unit-side signals of the queue sensor conditioner.
// The conditioner is the slave; the sensors plus Unit form the master.
interface sbqm_sensor_conditioner_if;
  logic backRaw;
  logic frontRaw;
  logic fullFlag;
  logic emptyFlag;
  logic upSignal;
  logic downSignal;
  logic rejectUp;
  logic rejectDown;
  logic backStable;
  logic frontStable;

  modport master (
    output backRaw, frontRaw, fullFlag, emptyFlag,
    input  upSignal, downSignal, rejectUp, rejectDown, backStable, frontStable
  );

  modport slave (
    input  backRaw, frontRaw, fullFlag, emptyFlag,
    output upSignal, downSignal, rejectUp, rejectDown, backStable, frontStable
  );
endinterface

// File: rtl/sbqm_sensor_conditioner.sv
// Synchronises, debounces and edge-detects the back/front queue sensors, then
// arbitrates the resulting enter/leave events against the Unit full/empty flags.
module sbqm_sensor_conditioner #(
  parameter int unsigned DB_CYCLES = 16
) (
  input logic                     clk,
  input logic                     reset,
  sbqm_sensor_conditioner_if.slave bus
);
  localparam int unsigned CNT_W = 8;
  localparam int unsigned NCH   = 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  if (DB_CYCLES < 2 || DB_CYCLES > 255) begin : g_bad_db_cycles
    $error("sbqm_sensor_conditioner: DB_CYCLES must be in 2..255");
  end

  // Channel 0 is the back (entry) sensor, channel 1 the front (teller) sensor.
  logic [NCH-1:0]   s1;
  logic [NCH-1:0]   s2;
  logic [NCH-1:0]   st;
  logic [NCH-1:0]   st_d;
  logic [CNT_W-1:0] cnt [NCH];

  logic pend_up;
  logic up_q;
  logic dn_q;
  logic rju_q;
  logic rjd_q;

  logic [NCH-1:0] ev;
  logic up_ok;
  logic dn_ok;
  logic up_nxt;
  logic dn_nxt;
  logic rju_nxt;
  logic rjd_nxt;
  logic pend_nxt;

  assign ev    = st & ~st_d;
  assign up_ok = ev[0] & ~bus.fullFlag;
  assign dn_ok = ev[1] & ~bus.emptyFlag;

  // Down wins a tie so a full queue can make room before the deferred entry.
  always_comb begin
    up_nxt   = 1'b0;
    dn_nxt   = 1'b0;
    rju_nxt  = 1'b0;
    rjd_nxt  = 1'b0;
    pend_nxt = 1'b0;
    if (pend_up) begin
      up_nxt = 1'b1;
    end else begin
      rju_nxt = ev[0] & bus.fullFlag;
      rjd_nxt = ev[1] & bus.emptyFlag;
      if (up_ok && dn_ok) begin
        dn_nxt   = 1'b1;
        pend_nxt = 1'b1;
      end else begin
        up_nxt = up_ok;
        dn_nxt = dn_ok;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1      <= '0;
      s2      <= '0;
      st      <= '0;
      st_d    <= '0;
      for (int i = 0; i < NCH; i++) cnt[i] <= '0;
      pend_up <= 1'b0;
      up_q    <= 1'b0;
      dn_q    <= 1'b0;
      rju_q   <= 1'b0;
      rjd_q   <= 1'b0;
    end else begin
      s1   <= {bus.frontRaw, bus.backRaw};
      s2   <= s1;
      st_d <= st;
      // Any sample agreeing with the stable level restarts the count.
      for (int i = 0; i < NCH; i++) begin
        if (s2[i] == st[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          st[i]  <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
      pend_up <= pend_nxt;
      up_q    <= up_nxt;
      dn_q    <= dn_nxt;
      rju_q   <= rju_nxt;
      rjd_q   <= rjd_nxt;
    end
  end

  assign bus.upSignal    = up_q;
  assign bus.downSignal  = dn_q;
  assign bus.rejectUp    = rju_q;
  assign bus.rejectDown  = rjd_q;
  assign bus.backStable  = st[0];
  assign bus.frontStable = st[1];
endmodule

// File: tb/tb_sbqm_sensor_conditioner.sv
// Bench for sbqm_sensor_conditioner: directed scenarios plus random sensor
// traffic, all checked every cycle against a sample-window reference model.
module tb_sbqm_sensor_conditioner;
  localparam int unsigned DB = 16;

  logic clk;
  logic rst;

  sbqm_sensor_conditioner_if bus ();

  sbqm_sensor_conditioner #(.DB_CYCLES(DB)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;
  int edge_n;

  // Reference model: raw delayed two edges, stable level flips once the last DB
  // delayed samples all disagree with it, an event is a consumed 0->1 flip.
  bit m_rd1 [2];
  bit m_rd2 [2];
  bit m_st  [2];
  bit m_rose[2];
  bit m_pend;
  bit m_hist[2][256];
  int m_nsmp[2];
  int m_wp  [2];
  bit e_up, e_dn, e_rju, e_rjd;
  int m_events;

  int n_up, n_dn, n_rju, n_rjd, n_coinc, n_fst;
  int first_up, first_dn, first_bst;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s at edge %0d: got=%0d expected=%0d", tag, edge_n, got, exp);
    end
  endtask

  function automatic void model_edge(bit br, bit fr, bit ff, bit ef, bit rs);
    bit raw[2];
    raw[0] = br;
    raw[1] = fr;
    e_up = 1'b0; e_dn = 1'b0; e_rju = 1'b0; e_rjd = 1'b0;
    if (!rs) begin
      for (int c = 0; c < 2; c++) begin
        m_rd1[c] = 1'b0; m_rd2[c] = 1'b0; m_st[c] = 1'b0;
        m_rose[c] = 1'b0; m_nsmp[c] = 0;
      end
      m_pend = 1'b0;
      return;
    end
    m_events += int'(m_rose[0]) + int'(m_rose[1]);
    if (m_pend) begin
      e_up   = 1'b1;
      m_pend = 1'b0;
    end else begin
      bit ok_u, ok_d;
      ok_u  = m_rose[0] && !ff;
      ok_d  = m_rose[1] && !ef;
      e_rju = m_rose[0] && ff;
      e_rjd = m_rose[1] && ef;
      if (ok_u && ok_d) begin
        e_dn   = 1'b1;
        m_pend = 1'b1;
      end else begin
        e_up = ok_u;
        e_dn = ok_d;
      end
    end
    for (int c = 0; c < 2; c++) begin
      bit all_diff;
      m_hist[c][m_wp[c]] = m_rd2[c];
      m_wp[c] = (m_wp[c] + 1) & 255;
      if (m_nsmp[c] < 256) m_nsmp[c]++;
      all_diff = (m_nsmp[c] >= int'(DB));
      for (int j = 0; j < int'(DB); j++)
        if (all_diff && m_hist[c][(m_wp[c] - 1 - j) & 255] == m_st[c]) all_diff = 1'b0;
      m_rose[c] = all_diff && !m_st[c];
      if (all_diff) m_st[c] = !m_st[c];
      m_rd2[c] = m_rd1[c];
      m_rd1[c] = raw[c];
    end
  endfunction

  task automatic clear_counts();
    n_up = 0; n_dn = 0; n_rju = 0; n_rjd = 0; n_coinc = 0; n_fst = 0;
    first_up = -1; first_dn = -1; first_bst = -1;
  endtask

  // One clock: drive, advance model, sample on the falling edge and compare.
  task automatic step(input bit br, input bit fr, input bit ff, input bit ef, input bit rs);
    bus.backRaw = br; bus.frontRaw = fr; bus.fullFlag = ff; bus.emptyFlag = ef; rst = rs;
    model_edge(br, fr, ff, ef, rs);
    @(posedge clk);
    edge_n++;
    @(negedge clk);
    check("upSignal",    int'(bus.upSignal),    int'(e_up));
    check("downSignal",  int'(bus.downSignal),  int'(e_dn));
    check("rejectUp",    int'(bus.rejectUp),    int'(e_rju));
    check("rejectDown",  int'(bus.rejectDown),  int'(e_rjd));
    check("backStable",  int'(bus.backStable),  int'(m_st[0]));
    check("frontStable", int'(bus.frontStable), int'(m_st[1]));
    check("up_dn_excl",  int'(bus.upSignal & bus.downSignal), 0);
    if (bus.upSignal)   begin n_up++;  if (first_up < 0) first_up = edge_n; end
    if (bus.downSignal) begin n_dn++;  if (first_dn < 0) first_dn = edge_n; end
    if (bus.rejectUp)   n_rju++;
    if (bus.rejectDown) n_rjd++;
    if (bus.rejectUp && bus.downSignal) n_coinc++;
    if (bus.frontStable) n_fst++;
    if (bus.backStable && first_bst < 0) first_bst = edge_n;
  endtask

  task automatic idle(input int n, input bit ff, input bit ef);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, ff, ef, 1'b1);
  endtask

  initial begin
    int k0;
    bit br, fr;
    int hb, hf;
    total = 0; bad = 0; edge_n = 0; m_events = 0;
    m_wp[0] = 0; m_wp[1] = 0;
    clear_counts();

    // Reset, then back sensor held high: entry pulse after the full latency.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1, 1'b0, 1'b0);
    clear_counts();
    k0 = edge_n + 1;
    for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t1_up_edge",  first_up,  k0 + int'(DB) + 2);
    check("t1_bst_edge", first_bst, k0 + int'(DB) + 1);
    check("t1_up_count", n_up, 1);
    idle(40, 1'b0, 1'b0);

    // Short front glitches never settle.
    clear_counts();
    for (int i = 0; i < 200; i++) step(1'b0, (i % 10) == 0, 1'b0, 1'b0, 1'b1);
    check("t2_dn_count",  n_dn, 0);
    check("t2_fst_count", n_fst, 0);

    // Simultaneous events with a full queue: up rejected alongside the down.
    clear_counts();
    for (int i = 0; i < 30; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    check("t3_coinc", n_coinc, 1);
    check("t3_up",    n_up, 0);
    check("t3_dn",    n_dn, 1);
    check("t3_rju",   n_rju, 1);
    idle(40, 1'b1, 1'b0);

    // Simultaneous events with room: down first, deferred up next cycle.
    clear_counts();
    for (int i = 0; i < 30; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check("t3b_up",       n_up, 1);
    check("t3b_dn",       n_dn, 1);
    check("t3b_up_after", first_up, first_dn + 1);
    idle(40, 1'b0, 1'b0);

    // Leave event on an empty queue is rejected.
    clear_counts();
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(30, 1'b0, 1'b1);
    check("t4_rjd", n_rjd, 1);
    check("t4_dn",  n_dn, 0);

    // Reset mid-debounce with the sensor still high: one event from release.
    clear_counts();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++)  step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    k0 = edge_n + 1;
    for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t5_up_count", n_up, 1);
    check("t5_up_edge",  first_up, k0 + int'(DB) + 2);
    idle(40, 1'b0, 1'b0);

    // Random sensor traffic with random flags; every rising edge is accounted for.
    clear_counts();
    m_events = 0;
    br = 1'b0; fr = 1'b0; hb = 1; hf = 1;
    for (int i = 0; i < 10000; i++) begin
      hb--; hf--;
      if (hb <= 0) begin
        br = !br;
        hb = int'($urandom_range(1, 48));
        if ($urandom_range(0, 3) == 0) begin fr = br; hf = hb; end
      end
      if (hf <= 0) begin
        fr = !fr;
        hf = int'($urandom_range(1, 48));
      end
      step(br, fr, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, 1'b1);
    end
    idle(60, 1'b0, 1'b0);
    check("rand_conservation", n_up + n_dn + n_rju + n_rjd, m_events);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
